// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pattern_gen
//  Brief    : Parametrised VGA timing generator with four selectable test
//             patterns, pixel-enable pacing and a wrapping frame counter.
//  Revision : 1.0  initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int CHECK_LOG2 = 5,
    parameter int FRAME_W    = 8,
    parameter int CNT_W      = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_SUM_W   = ((CNT_W > FRAME_W) ? CNT_W : FRAME_W) + 1;

    localparam logic [CNT_W-1:0] c_X_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_Y_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] c_BAR3_1   = CNT_W'(H_ACTIVE / 3);
    localparam logic [CNT_W-1:0] c_BAR3_2   = CNT_W'((2 * H_ACTIVE) / 3);

    localparam logic [COLOR_W-1:0] c_FULL = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] c_NONE = {COLOR_W{1'b0}};

    localparam logic [1:0] c_MODE_BARS3   = 2'd0;
    localparam logic [1:0] c_MODE_BARS8   = 2'd1;
    localparam logic [1:0] c_MODE_CHECKER = 2'd2;
    localparam logic [1:0] c_MODE_GRAD    = 2'd3;

    logic [CNT_W-1:0]   r_x;
    logic [CNT_W-1:0]   r_y;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [1:0]         r_mode_q;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic               r_frame_start;

    logic               w_line_end;
    logic               w_frame_end;
    logic               w_visible;
    logic               w_hs_on;
    logic               w_vs_on;
    logic [2:0]         w_bar8;
    logic [c_SUM_W-1:0] w_grad_sum;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;

    assign w_line_end  = (r_x == c_X_LAST);
    assign w_frame_end = w_line_end && (r_y == c_Y_LAST);
    assign w_visible   = (r_x < c_H_ACT) && (r_y < c_V_ACT);
    assign w_hs_on     = (r_x >= c_HS_START) && (r_x <= c_HS_END);
    assign w_vs_on     = (r_y >= c_VS_START) && (r_y <= c_VS_END);
    assign w_grad_sum  = c_SUM_W'(r_x) + c_SUM_W'(r_frame_cnt);

    // Bar index = number of the seven internal boundaries already passed.
    always_comb begin
        w_bar8 = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_x >= CNT_W'((k * H_ACTIVE) / 8)) begin
                w_bar8 = w_bar8 + 3'd1;
            end
        end
    end

    always_comb begin
        w_r = c_NONE;
        w_g = c_NONE;
        w_b = c_NONE;
        if (w_visible) begin
            case (r_mode_q)
                c_MODE_BARS3: begin
                    if (r_x < c_BAR3_1)      w_r = c_FULL;
                    else if (r_x < c_BAR3_2) w_g = c_FULL;
                    else                     w_b = c_FULL;
                end
                c_MODE_BARS8: begin
                    w_r = {COLOR_W{~w_bar8[1]}};
                    w_g = {COLOR_W{~w_bar8[2]}};
                    w_b = {COLOR_W{~w_bar8[0]}};
                end
                c_MODE_CHECKER: begin
                    w_r = {COLOR_W{r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2]}};
                    w_g = w_r;
                    w_b = w_r;
                end
                c_MODE_GRAD: begin
                    w_r = COLOR_W'(w_grad_sum >> 4);
                    w_g = COLOR_W'(r_y >> 4);
                    w_b = COLOR_W'(r_frame_cnt >> 2);
                end
                default: begin
                    w_r = c_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_cnt   <= '0;
            r_mode_q      <= c_MODE_BARS3;
            r_red         <= c_NONE;
            r_green       <= c_NONE;
            r_blue        <= c_NONE;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pix_ce && (r_x == '0) && (r_y == '0);
            if (pix_ce) begin
                r_red   <= w_r;
                r_green <= w_g;
                r_blue  <= w_b;
                r_de    <= w_visible;
                r_hsync <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
                r_vsync <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
                if (w_line_end) begin
                    r_x <= '0;
                    r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                // Mode only changes on the edge that returns the counters to (0,0).
                if (w_frame_end) begin
                    r_mode_q    <= mode;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_frame_start;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pattern_gen
//  Brief    : Directed self-checking bench for vga_pattern_gen on a reduced
//             20x10 raster (12x6 visible) so full frames stay short.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        pix_ce;
    logic [1:0]  mode;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, de, frame_start;
    logic [10:0] x, y;
    logic [7:0]  frame_cnt;

    int vectors;
    int miscompares;
    int cur_p;

    // Hand-derived bar index per x for eight bars over 12 pixels (boundaries 1,3,4,6,7,9,10).
    int          bar_of [12] = '{0, 1, 1, 2, 3, 3, 4, 5, 5, 6, 7, 7};
    logic [11:0] bar_rgb [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_pattern_gen #(
        .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .COLOR_W(4), .CHECK_LOG2(2), .FRAME_W(8), .CNT_W(11)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .mode(mode),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
        .x(x), .y(y), .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (p=%0d): got %0h expected %0h", tag, cur_p, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int m, input int px, input int py, input int fc);
        if (px >= 12 || py >= 6) return 12'h000;
        case (m)
            0: return (px < 4) ? 12'hF00 : (px < 8) ? 12'h0F0 : 12'h00F;
            1: return bar_rgb[bar_of[px]];
            2: return (((px / 4) + (py / 4)) % 2 == 1) ? 12'hFFF : 12'h000;
            default: return {4'(((px + fc) / 16) % 16), 4'((py / 16) % 16), 4'((fc / 4) % 16)};
        endcase
    endfunction

    // One full frame starting from counters at (0,0); optional mode write at pixel 60.
    task automatic run_frame(input int m, input int fc, input int pace, input int chg);
        int ex, ey;
        logic [11:0] hold_rgb;
        logic [10:0] hold_x;
        for (int p = 0; p < 200; p++) begin
            ex = p % 20;
            ey = p / 20;
            cur_p = p;
            if (chg >= 0 && p == 60) mode = 2'(chg);
            pix_ce = 1'b1;
            @(posedge clk);
            #1;
            if (pace > 1) pix_ce = 1'b0;
            check("rgb", 32'({red, green, blue}), 32'(exp_rgb(m, ex, ey, fc)));
            check("de", 32'(de), 32'(ex < 12 && ey < 6));
            check("hsync", 32'(hsync), 32'(!(ex >= 14 && ex <= 16)));
            check("vsync", 32'(vsync), 32'(!(ey >= 7 && ey <= 8)));
            check("frame_start", 32'(frame_start), 32'(p == 0));
            check("x", 32'(x), 32'((p + 1) % 20));
            check("y", 32'(y), 32'(((p + 1) / 20) % 10));
            check("frame_cnt", 32'(frame_cnt), 32'((p == 199) ? (fc + 1) % 256 : fc));
            hold_rgb = {red, green, blue};
            hold_x   = x;
            for (int k = 1; k < pace; k++) begin
                @(posedge clk);
                #1;
                check("idle_fs", 32'(frame_start), 32'd0);
                check("idle_rgb", 32'({red, green, blue}), 32'(hold_rgb));
                check("idle_x", 32'(x), 32'(hold_x));
            end
        end
        pix_ce = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cur_p       = -1;
        rst_n       = 1'b1;
        pix_ce      = 1'b1;
        mode        = 2'd2;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_de", 32'(de), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Mode input is 2 from reset, but the first frame must still be three bars.
        run_frame(0, 0, 1, -1);
        run_frame(2, 1, 1, 1);
        run_frame(1, 2, 1, 3);
        run_frame(3, 3, 1, -1);
        run_frame(3, 4, 4, -1);

        // Gradient red at (0,0) tracks frame_cnt>>4 across the 255->0 wrap.
        for (int f = 5; f <= 260; f++) begin
            cur_p = f;
            pix_ce = 1'b1;
            @(posedge clk);
            #1;
            check("grad_red00", 32'(red), 32'(((f % 256) / 16) % 16));
            check("grad_fs00", 32'(frame_start), 32'd1);
            check("grad_fcnt", 32'(frame_cnt), 32'(f % 256));
            repeat (199) @(posedge clk);
        end
        #1;

        // Advance into the visible area of frame 261 (counter at x=5,y=3) and reset mid-frame.
        repeat (65) @(posedge clk);
        #1;
        cur_p = 65;
        check("pre_rst_de", 32'(de), 32'd1);
        check("pre_rst_blue", 32'(blue), 32'd1);
        mode = 2'd1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_rgb", 32'({red, green, blue}), 32'd0);
        check("arst_de", 32'(de), 32'd0);
        check("arst_hsync", 32'(hsync), 32'd1);
        check("arst_x", 32'(x), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        check("arst_fcnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(0, 0, 1, -1);
        run_frame(1, 1, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
